// File: rtl/dca_matrix_lsu_rdata_aligner_pkg.sv
// Shared definitions for the LSU read-data aligner: FSM encoding and a width helper.
package dca_matrix_lsu_rdata_aligner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ralign_state_e;

  function automatic int clog2_fn(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dca_matrix_lsu_rdata_aligner_fifo.sv
// Output queue for the aligner: shift-register FIFO whose head entry is a register.
import dca_matrix_lsu_rdata_aligner_pkg::*;

module dca_ralign_fifo #(
  parameter int W     = 176,
  parameter int DEPTH = 4,
  parameter int CW    = clog2_fn(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  q   [DEPTH];
  logic [W-1:0]  q_n [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          pop;

  assign pop = out_ready & (cnt != '0);

  always_comb begin
    q_n   = q;
    cnt_n = cnt;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) q_n[i] = q[i+1];
      cnt_n = cnt - CW'(1);
    end
    // Push lands just behind the surviving entries, so push+pop keeps count.
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_n) q_n[i] = push_data;
      end
      cnt_n = cnt_n + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) cnt <= '0;
    else              cnt <= cnt_n;
  end

  always_ff @(posedge clk) begin
    q <= q_n;
  end

  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? q[0] : '0;
  assign count     = cnt;

endmodule

// File: rtl/ervp_barrel_shifter.sv
// Logarithmic logical right shifter (zero fill, non-circular).
module ERVP_BARREL_SHIFTER #(
  parameter int BW_DATA  = 32,
  parameter int BW_SHIFT = 5
) (
  input  logic [BW_DATA-1:0]  data_in,
  input  logic [BW_SHIFT-1:0] shift,
  output logic [BW_DATA-1:0]  data_out
);

  logic [BW_DATA-1:0] stg [BW_SHIFT+1];

  assign stg[0] = data_in;

  for (genvar s = 0; s < BW_SHIFT; s++) begin : g_stage
    assign stg[s+1] = shift[s] ? (stg[s] >> (1 << s)) : stg[s];
  end

  assign data_out = stg[BW_SHIFT];

endmodule

// File: rtl/dca_matrix_lsu_rdata_aligner.sv
// LSU read-data aligner: shifts row-buffer data by a bit offset and queues it.
// Define DCA_LSU_RALIGN_MERGE_EN to enable merging of straddling two-beat accesses.
import dca_matrix_lsu_rdata_aligner_pkg::*;

module dca_matrix_lsu_rdata_aligner #(
  parameter int BW_DATA         = 128,
  parameter int BW_INFO         = 48,
  parameter int FIFO_DEPTH      = 4,
  parameter int SUPPORT_SUBBYTE = 1,
  localparam int BW_SHIFT       = clog2_fn(BW_DATA),
  localparam int BW_COUNT       = clog2_fn(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BW_DATA-1:0]  in_data,
  input  logic [BW_SHIFT-1:0] in_offset,
  input  logic                in_split,
  input  logic [BW_INFO-1:0]  in_info,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BW_DATA-1:0]  out_data,
  output logic [BW_INFO-1:0]  out_info,
  output logic [BW_COUNT-1:0] count
);

  localparam logic [BW_SHIFT-1:0] OFF_MASK =
    (SUPPORT_SUBBYTE != 0) ? '1 : ~BW_SHIFT'(7);

  ralign_state_e       state, state_n;
  logic                in_fire;
  logic                split_eff;
  logic                push;
  logic                capture;
  logic [BW_SHIFT-1:0] eff_off;
  logic [BW_DATA-1:0]  sh_src, sh_out, push_data;
  logic [BW_SHIFT-1:0] sh_amt;

  assign in_ready = (count < BW_COUNT'(FIFO_DEPTH)) & ~flush & ~rst;
  assign in_fire  = in_valid & in_ready;
  assign eff_off  = in_offset & OFF_MASK;

`ifdef DCA_LSU_RALIGN_MERGE_EN
  logic [BW_DATA-1:0]  hold_data;
  logic [BW_SHIFT-1:0] hold_off;

  assign split_eff = in_split;
  assign sh_src    = (state == ST_HOLD) ? hold_data : in_data;
  assign sh_amt    = (state == ST_HOLD) ? hold_off  : eff_off;
  // Left shift by BW_DATA-hold_off done as <<1 then <<~hold_off, so hold_off=0 yields 0.
  assign push_data = (state == ST_HOLD) ? (sh_out | ((in_data << 1) << ~hold_off)) : sh_out;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_data <= '0;
      hold_off  <= '0;
    end else if (capture) begin
      hold_data <= in_data;
      hold_off  <= eff_off;
    end
  end
`else
  assign split_eff = 1'b0;
  assign sh_src    = in_data;
  assign sh_amt    = eff_off;
  assign push_data = sh_out;
`endif

  ERVP_BARREL_SHIFTER #(
    .BW_DATA  (BW_DATA),
    .BW_SHIFT (BW_SHIFT)
  ) u_shift (
    .data_in  (sh_src),
    .shift    (sh_amt),
    .data_out (sh_out)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) state <= ST_IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    capture = 1'b0;
    if (in_fire) begin
      case (state)
        ST_IDLE: begin
          if (split_eff) begin
            capture = 1'b1;
            state_n = ST_HOLD;
          end else begin
            push = 1'b1;
          end
        end
        ST_HOLD: begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  dca_ralign_fifo #(
    .W     (BW_DATA + BW_INFO),
    .DEPTH (FIFO_DEPTH),
    .CW    (BW_COUNT)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({in_info, push_data}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  ({out_info, out_data}),
    .count     (count)
  );

endmodule

// File: tb/tb_dca_matrix_lsu_rdata_aligner.sv
// Directed bench for dca_matrix_lsu_rdata_aligner (BW_DATA=32, FIFO_DEPTH=4).
module tb_dca_matrix_lsu_rdata_aligner;

  localparam int BW_DATA  = 32;
  localparam int BW_INFO  = 48;
  localparam int BW_SHIFT = 5;
  localparam int BW_COUNT = 3;

  logic                clk = 1'b0;
  logic                rst, flush, in_valid, in_split, out_ready;
  logic [BW_DATA-1:0]  in_data;
  logic [BW_SHIFT-1:0] in_offset;
  logic [BW_INFO-1:0]  in_info;

  logic                in_ready, out_valid;
  logic [BW_DATA-1:0]  out_data;
  logic [BW_INFO-1:0]  out_info;
  logic [BW_COUNT-1:0] count;

  logic                nb_in_ready, nb_out_valid;
  logic [BW_DATA-1:0]  nb_out_data;
  logic [BW_INFO-1:0]  nb_out_info;
  logic [BW_COUNT-1:0] nb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dca_matrix_lsu_rdata_aligner #(
    .BW_DATA(BW_DATA), .BW_INFO(BW_INFO), .FIFO_DEPTH(4), .SUPPORT_SUBBYTE(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_split(in_split), .in_info(in_info),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_info(out_info), .count(count)
  );

  dca_matrix_lsu_rdata_aligner #(
    .BW_DATA(BW_DATA), .BW_INFO(BW_INFO), .FIFO_DEPTH(4), .SUPPORT_SUBBYTE(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nb_in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_split(in_split), .in_info(in_info),
    .out_valid(nb_out_valid), .out_ready(out_ready), .out_data(nb_out_data),
    .out_info(nb_out_info), .count(nb_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [4:0] off, input logic sp,
                      input logic [47:0] inf);
    in_valid  = 1'b1;
    in_data   = d;
    in_offset = off;
    in_split  = sp;
    in_info   = inf;
    tick();
    in_valid  = 1'b0;
    in_split  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_split = 1'b0; out_ready = 1'b0;
    in_data = '0; in_offset = '0; in_info = '0;
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_info", 64'(out_info), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Plain offset shift
    beat(32'hAABBCCDD, 5'd8, 1'b0, 48'h1);
    chk("shift_valid", 64'(out_valid), 64'd1);
    chk("shift_data", 64'(out_data), 64'h00AABBCC);
    chk("shift_info", 64'(out_info), 64'h1);
    chk("shift_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_count", 64'(count), 64'd0);
    chk("pop_valid", 64'(out_valid), 64'd0);
    chk("pop_data_zero", 64'(out_data), 64'd0);
    chk("pop_info_zero", 64'(out_info), 64'd0);

    // Sub-byte offset, with and without sub-byte support
    beat(32'hAABBCCDD, 5'd11, 1'b0, 48'h2);
    chk("subbyte_on", 64'(out_data), 64'h00155779);
    chk("subbyte_off", 64'(nb_out_data), 64'h00AABBCC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("subbyte_drain", 64'(count), 64'd0);

`ifdef DCA_LSU_RALIGN_MERGE_EN
    beat(32'h44332211, 5'd16, 1'b1, 48'hA);
    chk("merge_b1_count", 64'(count), 64'd0);
    chk("merge_b1_valid", 64'(out_valid), 64'd0);
    beat(32'h88776655, 5'd5, 1'b1, 48'hB);
    chk("merge_data", 64'(out_data), 64'h66554433);
    chk("merge_info", 64'(out_info), 64'hB);
    chk("merge_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    beat(32'hCAFEBABE, 5'd0, 1'b1, 48'hC);
    beat(32'h11111111, 5'd0, 1'b0, 48'hD);
    chk("merge_off0_data", 64'(out_data), 64'hCAFEBABE);
    chk("merge_off0_info", 64'(out_info), 64'hD);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    beat(32'h44332211, 5'd16, 1'b1, 48'hA);
    chk("nomerge_data", 64'(out_data), 64'h00004433);
    chk("nomerge_info", 64'(out_info), 64'hA);
    chk("nomerge_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif
    chk("merge_drain", 64'(count), 64'd0);

    // Backpressure: five offered, four accepted, drained in order
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h1000 + i; in_offset = '0; in_split = 1'b0;
      in_info = 48'(i);
      #1;
      chk("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count_full", 64'(count), 64'd4);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_data", 64'(out_data), 64'h1000 + 64'(i));
      chk("bp_order_info", 64'(out_info), 64'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("bp_count_empty", 64'(count), 64'd0);

    // Simultaneous push and pop keeps count
    beat(32'h0000AAAA, 5'd0, 1'b0, 48'h5);
    in_valid = 1'b1; in_data = 32'h0000BBBB; in_info = 48'h6; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_count", 64'(count), 64'd1);
    chk("pushpop_data", 64'(out_data), 64'h0000BBBB);

    // Flush clears queued data and a half-merged access
    beat(32'h44332211, 5'd16, 1'b1, 48'h7);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    beat(32'h12345678, 5'd0, 1'b0, 48'h8);
    chk("after_flush_data", 64'(out_data), 64'h12345678);
    chk("after_flush_info", 64'(out_info), 64'h8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-merge
    beat(32'h44332211, 5'd16, 1'b1, 48'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    beat(32'h12345678, 5'd0, 1'b0, 48'h3);
    chk("after_rst_data", 64'(out_data), 64'h12345678);
    chk("after_rst_count", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dca_matrix_lsu_rdata_aligner.md
DCA_MATRIX_LSU_RDATA_ALIGNER -- requirements
Module: dca_matrix_lsu_rdata_aligner

Interface
- REQ-001 The module SHALL take parameter BW_DATA, default 128, as the row-buffer data width (power of 2, at least 32).
- REQ-002 The module SHALL take parameter BW_INFO, default 48, as the transaction-info width.
- REQ-003 The module SHALL take parameter FIFO_DEPTH, default 4, as the output queue depth (power of 2, at least 2).
- REQ-004 The module SHALL take parameter SUPPORT_SUBBYTE, default 1; when 0, bit-offset bits [2:0] are forced to 0.
- REQ-005 The module SHALL derive local parameter BW_SHIFT = log2(BW_DATA) as the bit-offset width.
- REQ-006 Ports: clk  in  1  single clock; all logic on rising edge.
- REQ-007 Ports: rst  in  1  reset, synchronous, active-high.
- REQ-008 Ports: flush  in  1  synchronous clear of queue and merge state.
- REQ-009 Ports: in_valid  in  1; in_ready  out  1; in_data  in  BW_DATA; in_offset  in  BW_SHIFT (bit offset); in_split  in  1 (first beat of a straddling access); in_info  in  BW_INFO.
- REQ-010 Ports: out_valid  out  1; out_ready  in  1; out_data  out  BW_DATA; out_info  out  BW_INFO.
- REQ-011 Ports: count  out  log2(FIFO_DEPTH)+1  current queue occupancy.

Function
- REQ-012 Input fire SHALL be in_valid & in_ready; output fire SHALL be out_valid & out_ready.
- REQ-013 in_ready SHALL equal (count < FIFO_DEPTH) & !flush, with no combinational path from out_ready.
- REQ-014 State machine states SHALL be IDLE and HOLD; reset state is IDLE.
- REQ-015 IDLE, fire, in_split=0: the module SHALL push in_data logically right-shifted by the effective offset (zero fill) together with in_info; state stays IDLE.
- REQ-016 IDLE, fire, in_split=1: the module SHALL capture hold_data=in_data and hold_off=effective offset, push nothing, and go to HOLD.
- REQ-017 HOLD, fire: the module SHALL push (hold_data >> hold_off) | (in_data << (BW_DATA - hold_off)) with the second beat's in_info, then return to IDLE; that beat's in_split and in_offset SHALL be ignored.
- REQ-018 When hold_off = 0, the merged word SHALL equal hold_data, because a shift by BW_DATA yields 0.
- REQ-019 A pushed word SHALL appear on out_data/out_valid the cycle after the push edge (latency 1); the queue SHALL be FIFO ordered.
- REQ-020 A push and a pop in the same cycle SHALL leave count unchanged; a pop SHALL never occur while count = 0.
- REQ-021 flush SHALL take priority over push and pop: on the next edge count=0, out_valid=0, state=IDLE, and hold registers are cleared.
- REQ-022 out_data and out_info SHALL be 0 whenever out_valid=0.

Reset
- REQ-023 On rst=1 at a clock edge, the module SHALL force count=0, out_valid=0, out_data=0, out_info=0, state=IDLE and hold_data=hold_off=0; in_ready SHALL be 0 while rst=1.
- REQ-024 Reset SHALL have priority over flush, push and pop, and SHALL drop any half-merged access mid-operation.

Configuration
- REQ-025 Macro DCA_LSU_RALIGN_MERGE_EN SHALL compile in the HOLD state, the hold registers and the merge datapath.
- REQ-026 Without DCA_LSU_RALIGN_MERGE_EN, in_split SHALL be ignored (treated as 0), the state SHALL stay permanently IDLE, and no hold registers SHALL exist.

Structure
- REQ-027 The shared package SHALL hold the state encoding (IDLE/HOLD) and the clog2-style width helper; the module SHALL instantiate ERVP_BARREL_SHIFTER for right shifts (zero fill, non-circular).
- REQ-028 The queue SHALL be one sub-module, dca_ralign_fifo (parametrised width BW_DATA+BW_INFO, depth FIFO_DEPTH, registered head output).

Verification (BW_DATA=32, FIFO_DEPTH=4)
- REQ-029 Offset shift: in_data=0xAABBCCDD, in_offset=8, in_split=0 -> out_data=0x00AABBCC one cycle later.
- REQ-030 Merge (macro on): beat 1 0x44332211 with offset 16 and split=1, then beat 2 0x88776655 -> out_data=0x66554433 with beat 2's info, count=1.
- REQ-031 Backpressure: out_ready=0, five beats offered -> four accepted, in_ready=0, count=4; then out_ready=1 -> in original order, count reaches 0.
- REQ-032 Sub-byte masking: SUPPORT_SUBBYTE=0, in_offset=11, in_data=0xAABBCCDD -> out_data=0x00AABBCC.
- REQ-033 Flush/reset in HOLD: split beat accepted, then flush (or rst) pulsed -> count=0, out_valid=0; next non-split beat 0x12345678 at offset 0 -> out_data=0x12345678, unmerged.
- REQ-034 Macro off: split=1 beat 0x44332211 at offset 16 -> out_data=0x00004433 pushed immediately.
